// File: rtl/dsm_pkg.sv
// Shared constants and types for the delta-sigma modulator front end:
// input width, PWM output codes and the interpolator state encoding.
package dsm_pkg;

  localparam int DSM_IN_W = 15;

  localparam logic [1:0] P1 = 2'b01;
  localparam logic [1:0] Z  = 2'b00;
  localparam logic [1:0] M1 = 2'b11;

  typedef enum logic [1:0] {
    PRIME0,
    PRIME1,
    RUN,
    HOLD
  } interp_state_t;

endpackage

// File: rtl/dsm_interp_fifo.sv
// Two-entry input buffer for the interpolator. Simultaneous push and pop are
// both honoured; the producer must not push when full, nor the consumer pop when empty.
module dsm_interp_fifo
  import dsm_pkg::*;
#(
  parameter int W = DSM_IN_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);

endmodule

// File: rtl/dsm_interp.sv
// Linear-interpolation upsampler feeding dsm_top.vin: one output per fast clock,
// 2^LOG2_OSR outputs per input sample. Define DSM_INTERP_DITHER_EN for +/-1 LFSR dither.
module dsm_interp
  import dsm_pkg::*;
#(
  parameter int IN_W     = DSM_IN_W,
  parameter int LOG2_OSR = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [IN_W-1:0] vin,
  output logic            out_valid,
  output logic            underrun,
  output interp_state_t   state_dbg
);

  localparam int ACC_W = IN_W + LOG2_OSR + 1;

  interp_state_t           state_q, state_d;
  logic signed [IN_W-1:0]  cur_q, cur_d, nxt_q, nxt_d, fifo_data;
  logic signed [ACC_W-1:0] acc_q, acc_d, delta_ext;
  logic [LOG2_OSR-1:0]     phase_q, phase_d;
  logic signed [IN_W:0]    delta;
  logic signed [IN_W-1:0]  vin_base, vin_d;
  logic                    underrun_d, out_valid_d;
  logic                    push, pop, fifo_full, fifo_empty;

  // Handshake: a sample transfers on any rising edge where in_valid && in_ready;
  // in_ready depends only on FIFO occupancy and reset, never on in_valid.
  assign in_ready  = reset && !fifo_full;
  assign push      = in_valid && in_ready;
  assign state_dbg = state_q;

  dsm_interp_fifo #(.W(IN_W)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  function automatic logic signed [ACC_W-1:0] scale(input logic signed [IN_W-1:0] s);
    return {s[IN_W-1], s, {LOG2_OSR{1'b0}}};
  endfunction

  assign delta     = {nxt_q[IN_W-1], nxt_q} - {cur_q[IN_W-1], cur_q};
  assign delta_ext = {{LOG2_OSR{delta[IN_W]}}, delta};

`ifdef DSM_INTERP_DITHER_EN
  logic [15:0]          lfsr_q;
  logic signed [IN_W:0] dith_sum;

  always_ff @(posedge clock) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
`endif

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    acc_d       = acc_q;
    phase_d     = phase_q;
    underrun_d  = underrun;
    out_valid_d = out_valid;
    pop         = 1'b0;
    case (state_q)
      PRIME0: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = fifo_data;
          state_d = PRIME1;
        end
      end
      PRIME1: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          nxt_d       = fifo_data;
          acc_d       = scale(cur_q);
          phase_d     = '0;
          out_valid_d = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (phase_q != '1) begin
          acc_d   = acc_q + delta_ext;
          phase_d = phase_q + LOG2_OSR'(1);
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = nxt_q;
          nxt_d   = fifo_data;
          acc_d   = scale(nxt_q);
          phase_d = '0;
        end else begin
          // Land exactly on the endpoint and park there until data returns.
          acc_d      = scale(nxt_q);
          phase_d    = '0;
          underrun_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = nxt_q;
          nxt_d   = fifo_data;
          acc_d   = scale(nxt_q);
          phase_d = '0;
          state_d = RUN;
        end
      end
      default: state_d = PRIME0;
    endcase

    // Dropping the redundant sign bit and the fraction is a floor divide by OSR.
    vin_base = acc_d[ACC_W-2:LOG2_OSR];
`ifdef DSM_INTERP_DITHER_EN
    dith_sum = {vin_base[IN_W-1], vin_base} +
               (lfsr_q[0] ? (IN_W+1)'(1) : {(IN_W+1){1'b1}});
    if (dith_sum[IN_W] != dith_sum[IN_W-1])
      vin_d = dith_sum[IN_W] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
    else
      vin_d = dith_sum[IN_W-1:0];
`else
    vin_d = vin_base;
`endif
    if (!out_valid_d) vin_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= PRIME0;
      cur_q     <= '0;
      nxt_q     <= '0;
      acc_q     <= '0;
      phase_q   <= '0;
      underrun  <= 1'b0;
      out_valid <= 1'b0;
      vin       <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      underrun  <= underrun_d;
      out_valid <= out_valid_d;
      vin       <= vin_d;
    end
  end

endmodule

// File: tb/tb_dsm_interp.sv
// Self-checking bench for dsm_interp (OSR=8): random and directed input
// streams scored against an ideal straight-line interpolation of the accepted samples.
module tb_dsm_interp;
  import dsm_pkg::*;

  localparam int IN_W = 15;
  localparam int OSR  = 8;

  logic            clock;
  logic            reset;
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] vin;
  logic            out_valid;
  logic            underrun;
  interp_state_t   state_dbg;

  dsm_interp #(.IN_W(IN_W), .LOG2_OSR(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vin       (vin),
    .out_valid (out_valid),
    .underrun  (underrun),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int edge_n = 0;
  always @(posedge clock) edge_n++;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int value;
    int seg_end;
    bit seg_start;
    int acc_edge;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_samples = 0;
  int   last_sample = 0;
  int   hold_val = 0;
  bit   exp_underrun = 1'b0;
  bit   saw_stall = 1'b0;

  function automatic int s15(input logic [IN_W-1:0] x);
    return int'($signed(x));
  endfunction

  function automatic int floor_div8(input int v);
    int q;
    q = v / OSR;
    if ((v % OSR != 0) && (v < 0)) q--;
    return q;
  endfunction

  function automatic void check_exact(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void check_val(input string name, input int act, input int exp);
    bit ok;
    n_checks++;
`ifdef DSM_INTERP_DITHER_EN
    ok = (act - exp <= 1) && (exp - act <= 1);
`else
    ok = (act == exp);
`endif
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Ideal model: each accepted sample closes a straight segment from the previous
  // one; OSR evenly spaced points, floored, starting at the segment start.
  function automatic void model_push(input int s, input int edge_a);
    exp_t e;
    if (n_samples > 0) begin
      for (int p = 0; p < OSR; p++) begin
        e.value     = floor_div8(last_sample * OSR + p * (s - last_sample));
        e.seg_end   = s;
        e.seg_start = (p == 0);
        e.acc_edge  = edge_a;
        exp_q.push_back(e);
      end
    end
    last_sample = s;
    n_samples++;
  endfunction

  // ---------------- monitor ----------------
  // A segment can only start once its endpoint sample was accepted on an earlier
  // edge than the one producing the current output; otherwise the output holds.
  always @(negedge clock) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0 || (exp_q[0].seg_start && exp_q[0].acc_edge >= edge_n)) begin
        check_val("hold_vin", s15(vin), hold_val);
        exp_underrun = 1'b1;
      end else begin
        mon_e = exp_q.pop_front();
        check_val("vin", s15(vin), mon_e.value);
        hold_val = mon_e.seg_end;
      end
      check_exact("underrun", int'(underrun), int'(exp_underrun));
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic send(input int v);
    int waited = 0;
    logic [31:0] bits;
    bits     = v;
    in_valid = 1'b1;
    in_data  = bits[IN_W-1:0];
    while (!in_ready && waited < 200) begin
      saw_stall = 1'b1;
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      check_exact("send_timeout", waited, 0);
    end else begin
      model_push(v, edge_n + 1);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() > 0 && w < 500) begin
      @(negedge clock);
      w++;
    end
    if (exp_q.size() > 0) check_exact("drain_timeout", exp_q.size(), 0);
    idle(4);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    n_samples    = 0;
    exp_underrun = 1'b0;
    @(negedge clock);
    check_exact("rst_vin", s15(vin), 0);
    check_exact("rst_out_valid", int'(out_valid), 0);
    check_exact("rst_underrun", int'(underrun), 0);
    check_exact("rst_in_ready", int'(in_ready), 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_exact("post_rst_in_ready", int'(in_ready), 1);
    @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  int seq1[3] = '{0, 800, 800};
  int seq2[3] = '{0, -7, -7};
  int seq3[3] = '{16383, -16384, -16384};
  int seq7[3] = '{-500, 500, 0};

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    do_reset();

    // Ramp, floor rounding and full-scale descent.
    foreach (seq1[i]) send(seq1[i]);
    idle(4);
    check_exact("t1_no_underrun_yet", int'(underrun), 0);
    drain();
    do_reset();
    foreach (seq2[i]) send(seq2[i]);
    drain();
    do_reset();
    foreach (seq3[i]) send(seq3[i]);
    drain();
    check_val("t3_end_value", s15(vin), -16384);

    // Source stall: hold then resume.
    do_reset();
    send(100);
    send(200);
    idle(20);
    check_exact("t4_underrun", int'(underrun), 1);
    check_val("t4_hold_value", s15(vin), 200);
    send(300);
    drain();

    // Continuous valid against the slow consumer.
    do_reset();
    saw_stall = 1'b0;
    for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 32767)) - 16384);
    check_exact("t5_backpressure_seen", int'(saw_stall), 1);
    drain();

    // Random values with random idle gaps.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      idle(int'($urandom_range(0, 5)));
      send(int'($urandom_range(0, 32767)) - 16384);
    end
    drain();

    // Reset in the middle of a ramp with samples still buffered.
    do_reset();
    for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 32767)) - 16384);
    idle(3);
    do_reset();
    idle(3);
    check_exact("t6_idle_out_valid", int'(out_valid), 0);
    foreach (seq7[i]) send(seq7[i]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
